// File: rtl/countdown_pkg.sv
`default_nettype none
// ============================================================================
// Module      : countdown_pkg
// Description : Shared state encoding and BCD constants for the countdown timer.
// Revision    : 1.0 - initial release
// ============================================================================
package countdown_pkg;

    localparam int c_DIGIT_W = 4;
    localparam logic [c_DIGIT_W-1:0] c_MAX_DIGIT = 4'd9;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2,
        ST_ALARM = 2'd3
    } state_t;

    // Out-of-range BCD digits saturate at 9.
    function automatic logic [c_DIGIT_W-1:0] clamp_digit(input logic [c_DIGIT_W-1:0] d);
        return (d > c_MAX_DIGIT) ? c_MAX_DIGIT : d;
    endfunction

endpackage
`default_nettype wire

// File: rtl/bcd_dec2.sv
`default_nettype none
// ============================================================================
// Module      : bcd_dec2
// Description : Combinational two-digit BCD decrement with borrow and zero flag.
// Revision    : 1.0 - initial release
// ============================================================================
module bcd_dec2
    import countdown_pkg::*;
(
    input  logic [c_DIGIT_W-1:0] i_hi,
    input  logic [c_DIGIT_W-1:0] i_lo,
    output logic [c_DIGIT_W-1:0] o_hi,
    output logic [c_DIGIT_W-1:0] o_lo,
    output logic                 o_zero
);

    always_comb begin
        o_hi = i_hi;
        o_lo = i_lo;
        if (i_lo != '0) begin
            o_lo = i_lo - 4'd1;
        end else if (i_hi != '0) begin
            o_lo = c_MAX_DIGIT;
            o_hi = i_hi - 4'd1;
        end
        // Saturates at 00; the flag reports a zero result.
        o_zero = (o_hi == '0) && (o_lo == '0);
    end

endmodule
`default_nettype wire

// File: rtl/countdown_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : countdown_ctrl
// Description : Two-digit BCD countdown timer with start/pause/load and alarm.
// Revision    : 1.0 - initial release
// ============================================================================
module countdown_ctrl
    import countdown_pkg::*;
#(
    parameter int ALARM_TICKS = 5,
    parameter int RESET_H     = 6,
    parameter int RESET_L     = 0
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       tick,
    input  logic       start,
    input  logic       pause,
    input  logic       load,
    input  logic [3:0] preset_h,
    input  logic [3:0] preset_l,
    output logic [3:0] TimeH,
    output logic [3:0] TimeL,
    output logic       beep,
    output logic       running,
    output logic       done
);

    localparam int c_TMR_W = $clog2(ALARM_TICKS + 1);
    localparam logic [c_TMR_W-1:0] c_TMR_LAST = c_TMR_W'(ALARM_TICKS - 1);

    state_t               r_state, w_state_nxt;
    logic [c_DIGIT_W-1:0] r_time_h, r_time_l, w_h_nxt, w_l_nxt;
    logic [c_TMR_W-1:0]   r_alarm_cnt, w_cnt_nxt;
    logic                 r_beep, r_running, r_done, w_done_nxt;
    logic [c_DIGIT_W-1:0] w_dec_h, w_dec_l;
    logic                 w_dec_zero;
    logic                 w_count_nz;

    bcd_dec2 u_dec (
        .i_hi   (r_time_h),
        .i_lo   (r_time_l),
        .o_hi   (w_dec_h),
        .o_lo   (w_dec_l),
        .o_zero (w_dec_zero)
    );

    assign w_count_nz = (r_time_h != '0) || (r_time_l != '0);

    // Strict event priority: an asserted higher-priority event consumes the
    // cycle even when the current state ignores it.
    always_comb begin
        w_state_nxt = r_state;
        w_h_nxt     = r_time_h;
        w_l_nxt     = r_time_l;
        w_cnt_nxt   = r_alarm_cnt;
        w_done_nxt  = 1'b0;
        case (r_state)
            ST_IDLE, ST_PAUSE: begin
                if (load) begin
                    w_h_nxt = clamp_digit(preset_h);
                    w_l_nxt = clamp_digit(preset_l);
                end else if (pause) begin
                    w_state_nxt = r_state;
                end else if (start && w_count_nz) begin
                    w_state_nxt = ST_RUN;
                end
            end
            ST_RUN: begin
                if (load) begin
                    w_state_nxt = ST_RUN;
                end else if (pause) begin
                    w_state_nxt = ST_PAUSE;
                end else if (start) begin
                    w_state_nxt = ST_RUN;
                end else if (tick) begin
                    w_h_nxt = w_dec_h;
                    w_l_nxt = w_dec_l;
                    if (w_dec_zero) begin
                        w_state_nxt = ST_ALARM;
                        w_done_nxt  = 1'b1;
                        w_cnt_nxt   = '0;
                    end
                end
            end
            ST_ALARM: begin
                if (load) begin
                    w_state_nxt = ST_ALARM;
                end else if (pause) begin
                    w_state_nxt = ST_IDLE;
                    w_cnt_nxt   = '0;
                end else if (start) begin
                    w_state_nxt = ST_ALARM;
                end else if (tick) begin
                    if (r_alarm_cnt == c_TMR_LAST) begin
                        w_state_nxt = ST_IDLE;
                        w_cnt_nxt   = '0;
                    end else begin
                        w_cnt_nxt = r_alarm_cnt + 1'b1;
                    end
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state     <= ST_IDLE;
            r_time_h    <= c_DIGIT_W'(RESET_H);
            r_time_l    <= c_DIGIT_W'(RESET_L);
            r_alarm_cnt <= '0;
            r_beep      <= 1'b0;
            r_running   <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_time_h    <= w_h_nxt;
            r_time_l    <= w_l_nxt;
            r_alarm_cnt <= w_cnt_nxt;
            r_beep      <= (w_state_nxt == ST_ALARM);
            r_running   <= (w_state_nxt == ST_RUN);
            r_done      <= w_done_nxt;
        end
    end

    assign TimeH   = r_time_h;
    assign TimeL   = r_time_l;
    assign beep    = r_beep;
    assign running = r_running;
    assign done    = r_done;

endmodule
`default_nettype wire

// File: doc/countdown_ctrl.md
COUNTDOWN_CTRL -- requirements
Module: countdown_ctrl

Interface
REQ-001 SHALL provide parameter ALARM_TICKS, default 5, number of tick pulses the alarm sounds before auto-clear.
REQ-002 SHALL provide parameter RESET_H, default 6, BCD tens digit loaded at reset.
REQ-003 SHALL provide parameter RESET_L, default 0, BCD units digit loaded at reset.
REQ-004 SHALL have port clock  input  1  sole clock; all state on rising edge.
REQ-005 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-006 SHALL have port tick  input  1  one-cycle count enable (1 Hz strobe from divider), clock domain of clock.
REQ-007 SHALL have port start  input  1  one-cycle pulse: start or resume.
REQ-008 SHALL have port pause  input  1  one-cycle pulse: pause run or silence alarm.
REQ-009 SHALL have port load  input  1  one-cycle pulse: load preset.
REQ-010 SHALL have port preset_h  input  4  BCD tens of preset.
REQ-011 SHALL have port preset_l  input  4  BCD units of preset.
REQ-012 SHALL have port TimeH  output  4  registered BCD tens of remaining count.
REQ-013 SHALL have port TimeL  output  4  registered BCD units of remaining count.
REQ-014 SHALL have port beep  output  1  registered; high throughout ALARM.
REQ-015 SHALL have port running  output  1  registered; high in RUN only.
REQ-016 SHALL have port done  output  1  registered one-cycle pulse on entry to ALARM.

Function
REQ-017 SHALL implement FSM states IDLE, RUN, PAUSE, ALARM.
REQ-018 Per-cycle priority SHALL be reset > load > pause > start > tick; lower-priority events in the same cycle are dropped.
REQ-019 load in IDLE or PAUSE SHALL write preset to TimeH/TimeL next edge, state unchanged; any preset digit >9 SHALL be clamped to 9; load in RUN/ALARM ignored.
REQ-020 start in IDLE or PAUSE SHALL enter RUN next edge if count != 00, else stay put.
REQ-021 pause in RUN SHALL enter PAUSE next edge, count frozen; pause in IDLE/PAUSE ignored.
REQ-022 tick in RUN SHALL decrement BCD count by one next edge: TimeL>0 -> TimeL-1; TimeL=0 -> TimeL=9, TimeH-1.
REQ-023 tick in RUN with count 01 SHALL produce 00 and enter ALARM on the same edge; done high exactly that next cycle.
REQ-024 tick outside RUN SHALL not change the count, except as alarm timer in ALARM.
REQ-025 In ALARM, beep SHALL be 1; an internal timer SHALL count ticks and on the ALARM_TICKS-th tick return to IDLE with beep 0.
REQ-026 pause in ALARM SHALL return to IDLE next edge (silence); start in ALARM ignored.
REQ-027 Count SHALL never wrap below 00; decrement from 00 is impossible by construction (RUN never holds 00).
REQ-028 Output latency SHALL be one clock from qualifying input to register update.

Reset
REQ-029 reset SHALL, on the next rising edge, force IDLE, TimeH=RESET_H, TimeL=RESET_L, beep=0, running=0, done=0, alarm timer=0, overriding any operation in progress.
REQ-030 reset asserted mid-RUN or mid-ALARM SHALL abort it with no residual done or beep pulse.

Structure
REQ-031 State encoding enum, BCD digit width (4) and max digit constant (9) SHALL live in shared package countdown_pkg.
REQ-032 BCD decrement with borrow SHALL be a sub-module bcd_dec2 (combinational two-digit decrement, zero flag); all other logic in countdown_ctrl.
REQ-033 Alarm timer width SHALL be $clog2(ALARM_TICKS+1).

Verification
REQ-034 Reset then no inputs -> TimeH=6, TimeL=0, beep=0, running=0 held indefinitely.
REQ-035 load with preset 1/2, start, 12 ticks -> count 12,11,...,01,00; running drops and done pulses one cycle on the 12th tick; beep high.
REQ-036 Count 10 in RUN, one tick -> 09; pause then 3 ticks -> stays 09; start, tick -> 08.
REQ-037 ALARM with ALARM_TICKS=5 -> beep high for exactly 5 ticks then IDLE; repeat with pause after 2 ticks -> IDLE next cycle, beep 0.
REQ-038 Same-cycle pause+tick in RUN at 05 -> PAUSE at 05; load with preset 0xF/0xC in PAUSE -> 99; load during RUN -> ignored.
REQ-039 reset asserted mid-RUN at 37 and mid-ALARM -> next cycle IDLE, 60, beep=0, done=0.
